alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU operand/opcode interface. Accepts one operation request at a time from the datapath control and translates immediate-form opcodes to the ALU's register forms. Drives registered Op/RA/RB into the combinational/multi-cycle ALU, waits the per-opcode latency, then captures ResultHi/ResultLo into result registers with HI/LO write enables. Sits between the control unit and the alu instance.

Parameters:
MUL_CYCLES, 34, cycles from issue to valid mul result (booth multiplier is clocked); legal range 1..63
DIV_CYCLES, 34, cycles from issue to valid div result; legal range 1..63
W, 32, operand/result width

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous, active-low reset
req_valid  in  1  request strobe
req_op  in  5  opcode (ALU encoding)
req_ra  in  W  operand A
req_rb  in  W  operand B / immediate
req_ready  out  1  controller can accept a request
alu_op  out  5  registered Op to ALU
alu_ra  out  W  registered RA to ALU
alu_rb  out  W  registered RB to ALU
alu_hi  in  W  ALU ResultHi
alu_lo  in  W  ALU ResultLo
res_valid  out  1  one-cycle pulse: res_hi/res_lo updated
res_hi  out  W  captured high result
res_lo  out  W  captured low result
hi_we  out  1  HI register write enable (pulse with res_valid)
lo_we  out  1  LO/Z write enable (pulse with res_valid)
div_zero  out  1  pulse with res_valid: DIV issued with RB==0
op_err  out  1  one-cycle pulse: illegal opcode rejected
busy  out  1  operation in flight

Behaviour:
- Opcodes: ADD=3 SUB=4 AND=5 OR=6 ROR=7 ROL=8 SHR=9 SHRA=10 SHL=11 ADDI=12 ANDI=13 ORI=14 DIV=15 MUL=16 NEG=17 NOT=18 SHLA=19. Legal: 3..19. Illegal: 0..2, 20..31.
- Translation at accept: ADDI->ADD, ANDI->AND, ORI->OR; all other legal opcodes pass unchanged.
- Latency LAT: MUL -> MUL_CYCLES, DIV -> DIV_CYCLES, all others -> 1.
- FSM states: IDLE, RUN.
- IDLE: req_ready=1, busy=0. On req_valid with a legal op: load alu_op/alu_ra/alu_rb and cnt=LAT-1, then go to RUN. On req_valid with an illegal op: op_err=1 next cycle, no ALU load, stay IDLE.
- RUN: req_ready=0, busy=1; alu_* held stable. If cnt!=0, decrement. If cnt==0, capture alu_hi/alu_lo into res_hi/res_lo, pulse res_valid next cycle, return to IDLE.
- res_valid is asserted in the cycle starting LAT edges after the accept edge. Back-to-back: a new request is accepted in the cycle res_valid is high (state is IDLE).
- Write enables: lo_we=1 for every completed op. hi_we=1 only for MUL/DIV.
- DIV with RB==0 (checked at accept):
  - still runs full DIV_CYCLES;
  - completes with res_valid=1, div_zero=1, hi_we=lo_we=0;
  - res_hi/res_lo are still captured.
- res_hi/res_lo hold their value until the next completion.
- alu_op returns to 0 (ALU default, zero result) in IDLE after completion; alu_ra/alu_rb hold.
- Reset (clear=0 at an edge), including mid-operation: state IDLE, cnt=0, every output register zero (alu_op, alu_ra, alu_rb, res_hi, res_lo, res_valid, hi_we, lo_we, div_zero, op_err). The in-flight operation is abandoned and produces no res_valid. req_ready=1 from the first cycle after reset.
- req_valid while in RUN is ignored; the requester must hold until req_ready.

Decomposition:
- Shared package alu_pkg: 5-bit opcode localparams (the values above), OP_IS_LEGAL range bounds, default MUL_CYCLES/DIV_CYCLES.
- One sub-module, alu_op_xlate: combinational, req_op -> translated op, legal flag, LAT-1 count. Everything else stays in alu_issue_ctrl.

Test Plan:
- ADD ra=5 rb=7 -> res_valid 1 cycle after accept; res_lo=12, res_hi=0, lo_we=1, hi_we=0.
- ADDI ra=0x10 rb=0x3 -> alu_op observed =3 (not 12); res_lo=0x13.
- MUL ra=6 rb=7, MUL_CYCLES=34 -> busy for 34 cycles, req_ready=0 throughout; res_lo=42, res_hi=0, hi_we=lo_we=1 at cycle 34.
- DIV ra=100 rb=0 -> res_valid after 34 cycles with div_zero=1, hi_we=lo_we=0. Next DIV 100/7 -> lo_we=hi_we=1, div_zero=0.
- req_op=0 and req_op=25 -> op_err pulse, no res_valid, alu_op stays 0, req_ready stays 1.
- MUL issued, clear=0 at cycle 10 -> all outputs 0 next cycle, no res_valid ever. After release, SUB 9-4 -> res_lo=5. Also back-to-back ADD accepted in the res_valid cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, state type and latency defaults for the ALU issue controller.
package alu_pkg;

  localparam int unsigned OP_W           = 5;
  localparam int unsigned CNT_W          = 6;
  localparam int unsigned MUL_CYCLES_DEF = 34;
  localparam int unsigned DIV_CYCLES_DEF = 34;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD  = 5'd3;
  localparam op_t OP_SUB  = 5'd4;
  localparam op_t OP_AND  = 5'd5;
  localparam op_t OP_OR   = 5'd6;
  localparam op_t OP_ROR  = 5'd7;
  localparam op_t OP_ROL  = 5'd8;
  localparam op_t OP_SHR  = 5'd9;
  localparam op_t OP_SHRA = 5'd10;
  localparam op_t OP_SHL  = 5'd11;
  localparam op_t OP_ADDI = 5'd12;
  localparam op_t OP_ANDI = 5'd13;
  localparam op_t OP_ORI  = 5'd14;
  localparam op_t OP_DIV  = 5'd15;
  localparam op_t OP_MUL  = 5'd16;
  localparam op_t OP_NEG  = 5'd17;
  localparam op_t OP_NOT  = 5'd18;
  localparam op_t OP_SHLA = 5'd19;

  localparam op_t OP_LEGAL_MIN = OP_ADD;
  localparam op_t OP_LEGAL_MAX = OP_SHLA;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_op_xlate.sv
// Request opcode decode: immediate forms fold to register forms, legality, latency-1 count.
module alu_op_xlate
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic [OP_W-1:0]  req_op,
  output logic [OP_W-1:0]  xop_c,
  output logic             legal_c,
  output logic [CNT_W-1:0] cnt_c
);

  always_comb begin
    xop_c   = req_op;
    legal_c = (req_op >= OP_LEGAL_MIN) && (req_op <= OP_LEGAL_MAX);
    cnt_c   = '0;
    case (req_op)
      OP_ADDI: xop_c = OP_ADD;
      OP_ANDI: xop_c = OP_AND;
      OP_ORI:  xop_c = OP_OR;
      OP_MUL:  cnt_c = CNT_W'(MUL_CYCLES - 1);
      OP_DIV:  cnt_c = CNT_W'(DIV_CYCLES - 1);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU initiator: accepts one request, drives registered operands, waits the opcode latency
// and captures the ALU result with HI/LO write enables.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned W          = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [W-1:0]    req_ra,
  input  logic [W-1:0]    req_rb,
  output logic            req_ready,
  output logic [OP_W-1:0] alu_op,
  output logic [W-1:0]    alu_ra,
  output logic [W-1:0]    alu_rb,
  input  logic [W-1:0]    alu_hi,
  input  logic [W-1:0]    alu_lo,
  output logic            res_valid,
  output logic [W-1:0]    res_hi,
  output logic [W-1:0]    res_lo,
  output logic            hi_we,
  output logic            lo_we,
  output logic            div_zero,
  output logic            op_err,
  output logic            busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              alu_op_q, alu_op_d;
  logic [W-1:0]     alu_ra_q, alu_ra_d, alu_rb_q, alu_rb_d;
  logic [W-1:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             res_valid_q, res_valid_d, hi_we_q, hi_we_d, lo_we_q, lo_we_d;
  logic             div_zero_q, div_zero_d, op_err_q, op_err_d;
  logic             ready_q, ready_d, busy_q, busy_d;

  op_t              xop_c;
  logic             legal_c;
  logic [CNT_W-1:0] lat_cnt_c;
  logic             dz_c, muldiv_c;

  alu_op_xlate #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_xlate (
    .req_op (req_op),
    .xop_c  (xop_c),
    .legal_c(legal_c),
    .cnt_c  (lat_cnt_c)
  );

  // Held operands still describe the in-flight op, so completion flags come from them.
  assign dz_c     = (alu_op_q == OP_DIV) && (alu_rb_q == '0);
  assign muldiv_c = (alu_op_q == OP_DIV) || (alu_op_q == OP_MUL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_ra_d    = alu_ra_q;
    alu_rb_d    = alu_rb_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_valid_d = 1'b0;
    hi_we_d     = 1'b0;
    lo_we_d     = 1'b0;
    div_zero_d  = 1'b0;
    op_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        alu_op_d = '0;
        if (req_valid) begin
          if (legal_c) begin
            state_d  = ST_RUN;
            alu_op_d = xop_c;
            alu_ra_d = req_ra;
            alu_rb_d = req_rb;
            cnt_d    = lat_cnt_c;
          end else begin
            op_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = ST_IDLE;
          alu_op_d    = '0;
          res_hi_d    = alu_hi;
          res_lo_d    = alu_lo;
          res_valid_d = 1'b1;
          lo_we_d     = !dz_c;
          hi_we_d     = muldiv_c && !dz_c;
          div_zero_d  = dz_c;
        end
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_ra_q    <= '0;
      alu_rb_q    <= '0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_valid_q <= 1'b0;
      hi_we_q     <= 1'b0;
      lo_we_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      op_err_q    <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_ra_q    <= alu_ra_d;
      alu_rb_q    <= alu_rb_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
      hi_we_q     <= hi_we_d;
      lo_we_q     <= lo_we_d;
      div_zero_q  <= div_zero_d;
      op_err_q    <= op_err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign alu_op    = alu_op_q;
  assign alu_ra    = alu_ra_q;
  assign alu_rb    = alu_rb_q;
  assign res_valid = res_valid_q;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;
  assign hi_we     = hi_we_q;
  assign lo_we     = lo_we_q;
  assign div_zero  = div_zero_q;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stub, directed vector table, reset/hold sequences
// and randomized requests checked against a request-level reference model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned MULC = 34;
  localparam int unsigned DIVC = 34;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic [4:0]  req_op;
  logic [31:0] req_ra, req_rb;
  logic        req_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_ra, alu_rb, alu_hi, alu_lo;
  logic        res_valid;
  logic [31:0] res_hi, res_lo;
  logic        hi_we, lo_we, div_zero, op_err, busy;

  always #5 clock = ~clock;

  alu_issue_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .W(W)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb),
    .req_ready(req_ready),
    .alu_op(alu_op), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
    .hi_we(hi_we), .lo_we(lo_we), .div_zero(div_zero), .op_err(op_err), .busy(busy)
  );

  typedef struct {
    bit          legal;
    logic [4:0]  xop;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          hwe;
    bit          lwe;
    bit          dz;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Environment ALU: returns {hi, lo}; unsigned mul/div, DIV by zero yields zero.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] aa, t;
    logic [31:0] r;
    aa = {a, a};
    case (op)
      5'd3:  return {32'h0, 32'(a + b)};
      5'd4:  return {32'h0, 32'(a - b)};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  begin t = aa >> b[4:0]; return {32'h0, t[31:0]}; end
      5'd8:  begin t = aa << b[4:0]; return {32'h0, t[63:32]}; end
      5'd9:  return {32'h0, a >> b[4:0]};
      5'd10: begin r = $signed(a) >>> b[4:0]; return {32'h0, r}; end
      5'd11, 5'd19: return {32'h0, a << b[4:0]};
      5'd15: return (b == 32'h0) ? 64'h0 : {a % b, a / b};
      5'd16: return {32'h0, a} * {32'h0, b};
      5'd17: return {32'h0, 32'(-a)};
      5'd18: return {32'h0, ~a};
      default: return 64'h0;
    endcase
  endfunction

  always_comb {alu_hi, alu_lo} = alu_fn(alu_op, alu_ra, alu_rb);

  // Reference model at request level: translation, latency and write-enable rules.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] ra,
                                 input logic [31:0] rb);
    exp_t e;
    logic [63:0] r;
    e.legal = (op >= 5'd3) && (op <= 5'd19);
    e.xop   = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : op;
    e.lat   = (op == 5'd16) ? int'(MULC) : (op == 5'd15) ? int'(DIVC) : 1;
    r       = alu_fn(e.xop, ra, rb);
    e.hi    = r[63:32];
    e.lo    = r[31:0];
    e.dz    = (op == 5'd15) && (rb == 32'h0);
    e.lwe   = !e.dz;
    e.hwe   = ((op == 5'd15) || (op == 5'd16)) && !e.dz;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_alu_op"}, 64'(alu_op), 64'(0));
    chk({nm, "_alu_ra"}, 64'(alu_ra), 64'(0));
    chk({nm, "_alu_rb"}, 64'(alu_rb), 64'(0));
    chk({nm, "_res"}, {res_hi, res_lo}, 64'(0));
    chk({nm, "_pulses"}, 64'({res_valid, hi_we, lo_we, div_zero, op_err}), 64'(0));
    chk({nm, "_ready_busy"}, 64'({req_ready, busy}), 64'(2'b10));
  endtask

  // Caller is at a negedge with the DUT idle; returns at the res_valid negedge
  // (legal op) or one cycle after the op_err pulse (illegal op).
  task automatic do_op(input vec_t v, input bit noise);
    exp_t e;
    int   k;
    bit   ok;
    e = v.e;
    chk("ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_op = v.op; req_ra = v.ra; req_rb = v.rb;
    @(negedge clock);
    req_valid = 1'b0;
    if (!e.legal) begin
      chk("err_pulse", 64'({op_err, res_valid, req_ready, busy}), 64'(4'b1010));
      chk("err_alu_op", 64'(alu_op), 64'(0));
      @(negedge clock);
      chk("err_clear", 64'({op_err, res_valid}), 64'(0));
      return;
    end
    chk("run_flags", 64'({busy, req_ready}), 64'(2'b10));
    chk("run_alu_op", 64'(alu_op), 64'(e.xop));
    chk("run_alu_ab", {alu_ra, alu_rb}, {v.ra, v.rb});
    k  = 0;
    ok = 1'b1;
    while (res_valid !== 1'b1 && k < 100) begin
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 5'($urandom);
        req_ra    = $urandom;
      end
      @(negedge clock);
      k++;
      if (res_valid !== 1'b1 &&
          (alu_op !== e.xop || alu_ra !== v.ra || alu_rb !== v.rb ||
           req_ready !== 1'b0 || busy !== 1'b1 || op_err !== 1'b0))
        ok = 1'b0;
    end
    req_valid = 1'b0;
    chk("run_stable", 64'(ok), 64'(1));
    chk("latency", 64'(k), 64'(e.lat));
    chk("res_hi_lo", {res_hi, res_lo}, {e.hi, e.lo});
    chk("we_dz", 64'({hi_we, lo_we, div_zero, op_err}), 64'({e.hwe, e.lwe, e.dz, 1'b0}));
    chk("done_idle", 64'({alu_op, busy, req_ready}), 64'(7'b0000001));
  endtask

  vec_t tbl[12];

  initial begin
    int   seen;
    vec_t v;

    tbl[0]  = '{5'd3,  32'd5,        32'd7, '{1'b1, 5'd3,  1,  32'h0, 32'd12,       1'b0, 1'b1, 1'b0}};
    tbl[1]  = '{5'd12, 32'h10,       32'h3, '{1'b1, 5'd3,  1,  32'h0, 32'h13,       1'b0, 1'b1, 1'b0}};
    tbl[2]  = '{5'd16, 32'd6,        32'd7, '{1'b1, 5'd16, 34, 32'h0, 32'd42,       1'b1, 1'b1, 1'b0}};
    tbl[3]  = '{5'd15, 32'd100,      32'd0, '{1'b1, 5'd15, 34, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1}};
    tbl[4]  = '{5'd15, 32'd100,      32'd7, '{1'b1, 5'd15, 34, 32'd2, 32'd14,       1'b1, 1'b1, 1'b0}};
    tbl[5]  = '{5'd0,  32'd1,        32'd2, '{1'b0, 5'd0,  0,  32'h0, 32'h0,        1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{5'd25, 32'd1,        32'd2, '{1'b0, 5'd0,  0,  32'h0, 32'h0,        1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{5'd13, 32'hF0F0,     32'h0FF0, '{1'b1, 5'd5, 1, 32'h0, 32'h00F0,    1'b0, 1'b1, 1'b0}};
    tbl[8]  = '{5'd14, 32'hF000,     32'h000F, '{1'b1, 5'd6, 1, 32'h0, 32'hF00F,    1'b0, 1'b1, 1'b0}};
    tbl[9]  = '{5'd16, 32'hFFFFFFFF, 32'd2, '{1'b1, 5'd16, 34, 32'd1, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0}};
    tbl[10] = '{5'd7,  32'h1,        32'd1, '{1'b1, 5'd7,  1,  32'h0, 32'h80000000, 1'b0, 1'b1, 1'b0}};
    tbl[11] = '{5'd20, 32'd3,        32'd4, '{1'b0, 5'd0,  0,  32'h0, 32'h0,        1'b0, 1'b0, 1'b0}};

    clear = 1'b0; req_valid = 1'b0; req_op = '0; req_ra = '0; req_rb = '0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    clear = 1'b1;
    @(negedge clock);

    // Directed vectors, issued back-to-back where legal.
    foreach (tbl[i]) do_op(tbl[i], 1'b0);

    // Result hold and single-cycle pulse after completion.
    do_op('{5'd3, 32'd1, 32'd2, '{1'b1, 5'd3, 1, 32'h0, 32'd3, 1'b0, 1'b1, 1'b0}}, 1'b0);
    @(negedge clock);
    chk("pulse_end", 64'({res_valid, hi_we, lo_we, div_zero}), 64'(0));
    chk("res_hold", {res_hi, res_lo}, 64'(3));

    // Reset in the middle of a MUL: abandoned, never completes.
    req_valid = 1'b1; req_op = 5'd16; req_ra = 32'd6; req_rb = 32'd7;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    chk_zero("midrst");
    clear = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clock);
      if (res_valid === 1'b1) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'(0));
    do_op('{5'd4, 32'd9, 32'd4, '{1'b1, 5'd4, 1, 32'h0, 32'd5, 1'b0, 1'b1, 1'b0}}, 1'b0);

    // Randomized requests with bus noise while busy.
    for (int n = 0; n < 150; n++) begin
      v.op = 5'($urandom);
      v.ra = $urandom;
      v.rb = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      v.e  = model(v.op, v.ra, v.rb);
      do_op(v, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
